// File: rtl/alu_mcycle.sv
// alu_mcycle: EX-stage ALU, single-cycle logic/arithmetic plus an iterative shift-add multiplier.
// Define ALU_MUL_EARLY_EXIT_EN to end a multiply as soon as the remaining multiplier is zero.
module alu_mcycle #(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned BITS_PER_CYCLE = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              valid,
    input  logic              flush,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_in_0,
    input  logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero_flag,
    output logic              busy
);
    localparam int unsigned K    = DATA_W / BITS_PER_CYCLE;
    localparam int unsigned CntW = $clog2(K) + 1;
    localparam int unsigned ShW  = $clog2(DATA_W);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] OpAnd = 4'd0;
    localparam logic [3:0] OpOr  = 4'd1;
    localparam logic [3:0] OpAdd = 4'd2;
    localparam logic [3:0] OpSll = 4'd3;
    localparam logic [3:0] OpSrl = 4'd4;
    localparam logic [3:0] OpSub = 4'd6;
    localparam logic [3:0] OpSlt = 4'd7;
    localparam logic [3:0] OpMul = 4'd8;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0] comb_res;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] mplier_shr;
    logic              mul_start;
    logic              last_iter;

    always_comb begin
        comb_res = '0;
        case (alu_control)
            OpAnd:   comb_res = alu_in_0 & alu_in_1;
            OpOr:    comb_res = alu_in_0 | alu_in_1;
            OpAdd:   comb_res = alu_in_0 + alu_in_1;
            OpSll:   comb_res = alu_in_0 << alu_in_1[ShW-1:0];
            OpSrl:   comb_res = alu_in_0 >> alu_in_1[ShW-1:0];
            OpSub:   comb_res = alu_in_0 - alu_in_1;
            OpSlt:   comb_res = {{(DATA_W-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
            default: comb_res = '0;
        endcase
    end

    assign mul_start  = (state_q == StIdle) && valid && !flush && (alu_control == OpMul);
    assign partial    = mcand_q * DATA_W'(mplier_q[BITS_PER_CYCLE-1:0]);
    assign mplier_shr = mplier_q >> BITS_PER_CYCLE;

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CntW'(K - 1)) || (mplier_shr == '0);
`else
    assign last_iter = (cnt_q == CntW'(K - 1));
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        // Flush only redirects the FSM; datapath registers keep their contents.
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mul_start) begin
                        acc_d    = '0;
                        mcand_d  = alu_in_0;
                        mplier_d = alu_in_1;
                        cnt_d    = '0;
                        state_d  = StMul;
`ifdef ALU_MUL_EARLY_EXIT_EN
                        if (alu_in_1 == '0) state_d = StDone;
`endif
                    end
                end
                StMul: begin
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << BITS_PER_CYCLE;
                    mplier_d = mplier_shr;
                    cnt_d    = cnt_q + CntW'(1);
                    if (last_iter) state_d = StDone;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // DONE presents the product for the single cycle the pipeline advances.
    assign alu_out   = (state_q == StDone) ? acc_q : comb_res;
    assign zero_flag = (alu_out == '0);
    assign busy      = mul_start || (state_q == StMul);

endmodule

// File: tb/tb_alu_mcycle.sv
// Directed self-checking bench for alu_mcycle (DATA_W=64, BITS_PER_CYCLE=16).
module tb_alu_mcycle;
    localparam logic [3:0] OpAnd = 4'd0, OpOr = 4'd1, OpAdd = 4'd2, OpSll = 4'd3;
    localparam logic [3:0] OpSrl = 4'd4, OpSub = 4'd6, OpSlt = 4'd7, OpMul = 4'd8;
    localparam logic [1:0] TbIdle = 2'd0;
`ifdef ALU_MUL_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    logic        clk, arst, valid, flush;
    logic [3:0]  ctl;
    logic [63:0] a, b, alu_out;
    logic        zero_flag, busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_mcycle #(.DATA_W(64), .BITS_PER_CYCLE(16)) dut (
        .clk        (clk),
        .arst       (arst),
        .valid      (valid),
        .flush      (flush),
        .alu_control(ctl),
        .alu_in_0   (a),
        .alu_in_1   (b),
        .alu_out    (alu_out),
        .zero_flag  (zero_flag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NC = 12;
    localparam logic [3:0] CC [NC] = '{OpAdd, OpSub, OpSlt, OpSrl, OpAnd, OpOr, OpSll, OpSlt,
                                       4'd5, 4'd15, OpMul, OpSub};
    localparam logic CV [NC] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [63:0] CA [NC] = '{64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 64'hF0F0, 64'hF0F0, 64'd1, 64'd1, 64'd5, 64'd7, 64'd6, 64'd0};
    localparam logic [63:0] CB [NC] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 64'd1, 64'd63,
        64'h0FF0, 64'h0FF0, 64'h41, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd3, 64'd7, 64'd1};
    localparam logic [63:0] CE [NC] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd1, 64'd1,
        64'h00F0, 64'hFFF0, 64'd2, 64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (dut.state_q !== TbIdle) begin n_err++; $display("FAIL reset_state: got %0d want 0", dut.state_q); end
        n_cmp++; if (dut.acc_q !== 64'd0) begin n_err++; $display("FAIL reset_acc: got %h want 0", dut.acc_q); end
        n_cmp++; if (alu_out !== 64'd0 || zero_flag !== 1'b1) begin
            n_err++; $display("FAIL reset_out: got %h/%b want 0/1", alu_out, zero_flag); end
        arst = 1'b0;
    endtask

    task automatic test_comb();
        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            valid = CV[i]; ctl = CC[i]; a = CA[i]; b = CB[i];
            #1;
            n_cmp++; if (alu_out !== CE[i] || zero_flag !== (CE[i] == 64'd0) || busy !== 1'b0) begin
                n_err++;
                $display("FAIL comb_%0d: got out=%h z=%b busy=%b want out=%h z=%b busy=0",
                         i, alu_out, zero_flag, busy, CE[i], (CE[i] == 64'd0));
            end
        end
        @(negedge clk); valid = 1'b0;
    endtask

    task automatic test_mul_basic();
        int n;
        @(negedge clk);
        valid = 1'b1; ctl = OpMul; a = 64'h1234_5678; b = 64'h9ABC_DEF0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); #1; end
        n_cmp++; if (n !== (EarlyExit ? 3 : 5)) begin
            n_err++; $display("FAIL mulb_busy_cycles: got %0d want %0d", n, EarlyExit ? 3 : 5); end
        n_cmp++; if (alu_out !== 64'h0B00_EA4E_242D_2080 || zero_flag !== 1'b0) begin
            n_err++; $display("FAIL mulb_result: got %h z=%b want 0b00ea4e242d2080 z=0", alu_out, zero_flag); end
        // valid still held: DONE must fall to IDLE, which then starts a fresh multiply
        @(negedge clk); #1;
        n_cmp++; if (dut.state_q !== TbIdle || busy !== 1'b1) begin
            n_err++; $display("FAIL mulb_after_done: got state=%0d busy=%b want 0/1", dut.state_q, busy); end
        @(negedge clk); valid = 1'b0; flush = 1'b1; #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mulb_flush_busy: got %b want 1", busy); end
        @(negedge clk); flush = 1'b0; #1;
        n_cmp++; if (dut.state_q !== TbIdle || busy !== 1'b0) begin
            n_err++; $display("FAIL mulb_flushed: got state=%0d busy=%b want 0/0", dut.state_q, busy); end
    endtask

    task automatic test_mul_values();
        logic [63:0] va [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234};
        logic [63:0] vb [3] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        logic [63:0] ve [3] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'd1, 64'd0};
        int          vn [3];
        int          n;
        vn[0] = EarlyExit ? 2 : 5; vn[1] = 5; vn[2] = EarlyExit ? 1 : 5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid = 1'b1; ctl = OpMul; a = va[i]; b = vb[i];
            #1;
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                n++; @(negedge clk);
                if (i == 0) begin a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h1111_2222_3333_4444; end
                #1;
            end
            n_cmp++; if (n !== vn[i] || alu_out !== ve[i] || zero_flag !== (ve[i] == 64'd0)) begin
                n_err++;
                $display("FAIL mulv_%0d: got busy=%0d out=%h z=%b want busy=%0d out=%h", i, n,
                         alu_out, zero_flag, vn[i], ve[i]);
            end
            @(negedge clk); valid = 1'b0;
        end
    endtask

    task automatic test_flush();
        @(negedge clk); valid = 1'b1; ctl = OpMul; a = 64'd6; b = 64'd7; flush = 1'b1; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
        @(negedge clk); flush = 1'b0; valid = 1'b0; ctl = OpAdd; a = 64'd1; b = 64'd1; #1;
        n_cmp++; if (dut.state_q !== TbIdle || alu_out !== 64'd2) begin
            n_err++; $display("FAIL flush_idle_nostart: got state=%0d out=%h want 0/2", dut.state_q, alu_out); end
        @(negedge clk); valid = 1'b1; ctl = OpMul; a = 64'd5; b = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        @(negedge clk); #1;
        @(negedge clk); flush = 1'b1; #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_mul_busy: got %b want 1", busy); end
        @(negedge clk); flush = 1'b0; valid = 1'b0; ctl = OpAdd; a = 64'd1; b = 64'd1; #1;
        n_cmp++; if (dut.state_q !== TbIdle || busy !== 1'b0 || alu_out !== 64'd2 || zero_flag !== 1'b0) begin
            n_err++;
            $display("FAIL flush_mul_after: got state=%0d busy=%b out=%h want 0/0/2", dut.state_q, busy, alu_out);
        end
    endtask

    task automatic test_arst_mid();
        int n;
        @(negedge clk); valid = 1'b1; ctl = OpMul; a = 64'd5; b = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        @(negedge clk); valid = 1'b0; #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy: got %b want 1", busy); end
        #1 arst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || dut.state_q !== TbIdle || dut.acc_q !== 64'd0) begin
            n_err++;
            $display("FAIL arst_async: got busy=%b state=%0d acc=%h want 0/0/0", busy, dut.state_q, dut.acc_q);
        end
        #1 arst = 1'b0;
        @(negedge clk); valid = 1'b1; ctl = OpMul; a = 64'd6; b = 64'd7; #1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); #1; end
        n_cmp++; if (n !== (EarlyExit ? 2 : 5) || alu_out !== 64'd42) begin
            n_err++; $display("FAIL arst_next_mul: got busy=%0d out=%h want %0d/42", n, alu_out, EarlyExit ? 2 : 5); end
        @(negedge clk); valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk); valid = 1'b1; ctl = OpMul; a = 64'd2; b = 64'd3; #1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); #1; end
        n_cmp++; if (n + 1 !== (EarlyExit ? 3 : 6) || alu_out !== 64'd6) begin
            n_err++; $display("FAIL b2b_first: got cycles=%0d out=%h want %0d/6", n + 1, alu_out, EarlyExit ? 3 : 6); end
        @(negedge clk); a = 64'd4; b = 64'd5; #1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); #1; end
        n_cmp++; if (n + 1 !== (EarlyExit ? 3 : 6) || alu_out !== 64'd20) begin
            n_err++; $display("FAIL b2b_second: got cycles=%0d out=%h want %0d/20", n + 1, alu_out, EarlyExit ? 3 : 6); end
        @(negedge clk); valid = 1'b0;
    endtask

    initial begin
        arst = 1'b1; valid = 1'b0; flush = 1'b0; ctl = OpAnd; a = '0; b = '0;
        test_reset();
        test_comb();
        test_mul_basic();
        test_mul_values();
        test_flush();
        test_arst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
